div_pipe_arb: RTL and testbench

Round-robin arbiter and tag tracker that shares one `div_pipe` instance (fully pipelined, 1 op/cycle, latency L = DATA_W/OPERS_PER_STAGE) among N_REQ requesters. It accepts at most one division per cycle, carries each operation's requester ID and divide-by-zero flag alongside the pipeline, and returns each result to the requester that issued it. `div_pipe` has no valid or reset, so all sequencing state lives in this block.

---
 rtl/div_pipe_arb_if.sv | 26 ++
 rtl/div_pipe_arb.sv | 182 ++++++++++++++++++
 tb/tb_div_pipe_arb.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/div_pipe_arb_if.sv
// Request/response bundle between requesters and the shared divider arbiter.
// Operand buses are flattened: requester i occupies bits [i*DATA_W +: DATA_W].
interface div_pipe_arb_if #(
  parameter int DATA_W = 32,
  parameter int N_REQ  = 4
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*DATA_W-1:0] req_dividend;
  logic [N_REQ*DATA_W-1:0] req_divisor;
  logic [N_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]       rsp_quotient;
  logic [DATA_W-1:0]       rsp_remainder;
  logic                    rsp_div0;
  logic                    busy;

  modport master (
    output req_valid, req_dividend, req_divisor,
    input  req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_div0, busy
  );

  modport slave (
    input  req_valid, req_dividend, req_divisor,
    output req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_div0, busy
  );
endinterface

// File: rtl/div_pipe_arb.sv
// Round-robin arbiter sharing one fully pipelined unsigned divider among N_REQ requesters.
// One accept per cycle; result pulses back to its owner L+2 edges after capture, no backpressure.

// Restoring divider, OPERS_PER_STAGE quotient bits per stage; no valid, no reset.
module div_pipe #(
  parameter int DATA_W          = 32,
  parameter int OPERS_PER_STAGE = 8
) (
  input  logic              clk,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W-1:0] quotient_o,
  output logic [DATA_W-1:0] remainder_o
);
  localparam int L = DATA_W / OPERS_PER_STAGE;

  function automatic logic [2*DATA_W-1:0] step(input logic [DATA_W-1:0] rem_in,
                                                input logic [DATA_W-1:0] num_in,
                                                input logic [DATA_W-1:0] den);
    logic [DATA_W:0]   r;
    logic [DATA_W-1:0] n;
    r = {1'b0, rem_in};
    n = num_in;
    for (int j = 0; j < OPERS_PER_STAGE; j++) begin
      r = {r[DATA_W-1:0], n[DATA_W-1]};
      n = {n[DATA_W-2:0], 1'b0};
      if (r >= {1'b0, den}) begin
        r    = r - {1'b0, den};
        n[0] = 1'b1;
      end
    end
    return {r[DATA_W-1:0], n};
  endfunction

  for (genvar s = 0; s < L; s++) begin : g_stage
    logic [DATA_W-1:0] rem_in, num_in, den_in;
    logic [DATA_W-1:0] rem_q, num_q;

    if (s == 0) begin : g_first
      assign rem_in = '0;
      assign num_in = dividend_i;
      assign den_in = divisor_i;
    end else begin : g_rest
      assign rem_in = g_stage[s-1].rem_q;
      assign num_in = g_stage[s-1].num_q;
      assign den_in = g_stage[s-1].g_den.den_q;
    end

    always_ff @(posedge clk) begin
      {rem_q, num_q} <= step(rem_in, num_in, den_in);
    end

    // The last stage has no successor, so it does not carry the divisor.
    if (s < L-1) begin : g_den
      logic [DATA_W-1:0] den_q;
      always_ff @(posedge clk) den_q <= den_in;
    end
  end

  assign quotient_o  = g_stage[L-1].num_q;
  assign remainder_o = g_stage[L-1].rem_q;
endmodule

module div_pipe_arb #(
  parameter int DATA_W          = 32,
  parameter int OPERS_PER_STAGE = 8,
  parameter int N_REQ           = 4
) (
  input  logic          clk,
  input  logic          rst,
  div_pipe_arb_if.slave bus
);
  localparam int L    = DATA_W / OPERS_PER_STAGE;
  localparam int ID_W = (N_REQ > 2) ? $clog2(N_REQ) : 1;

  logic [ID_W-1:0]   ptr_q, ptr_d, gnt_id, idx;
  logic              gnt_any;
  logic [N_REQ-1:0]  grant;
  logic [DATA_W-1:0] sel_a, sel_b;

  logic              iss_v_q, iss_div0_q;
  logic [ID_W-1:0]   iss_id_q;
  logic [DATA_W-1:0] iss_a_q, iss_b_q;

  logic [L-1:0]      sp_v_q;
  logic              sp_div0_q [L];
  logic [ID_W-1:0]   sp_id_q   [L];
  logic [DATA_W-1:0] sp_a_q    [L];

  logic [DATA_W-1:0] dp_quo, dp_rem;
  logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_quo_q, rsp_quo_d, rsp_rem_q, rsp_rem_d;
  logic              rsp_div0_q, rsp_div0_d;

  // First valid requester at or after ptr wins; nobody is granted during reset.
  always_comb begin
    grant   = '0;
    gnt_any = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    sel_a   = '0;
    sel_b   = '0;
    if (!rst) begin
      for (int k = 0; k < N_REQ; k++) begin
        idx = ID_W'((int'(ptr_q) + k) % N_REQ);
        if (!gnt_any && bus.req_valid[idx]) begin
          gnt_any = 1'b1;
          gnt_id  = idx;
        end
      end
    end
    if (gnt_any) grant[gnt_id] = 1'b1;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_id == ID_W'(i)) begin
        sel_a = bus.req_dividend[i*DATA_W +: DATA_W];
        sel_b = bus.req_divisor[i*DATA_W +: DATA_W];
      end
    end
    ptr_d = gnt_any ? ID_W'((int'(gnt_id) + 1) % N_REQ) : ptr_q;
  end

  div_pipe #(.DATA_W(DATA_W), .OPERS_PER_STAGE(OPERS_PER_STAGE)) u_div (
    .clk         (clk),
    .dividend_i  (iss_a_q),
    .divisor_i   (iss_b_q),
    .quotient_o  (dp_quo),
    .remainder_o (dp_rem)
  );

  always_comb begin
    rsp_valid_d = sp_v_q[L-1] ? (N_REQ'(1) << sp_id_q[L-1]) : '0;
    rsp_quo_d   = sp_div0_q[L-1] ? '1 : dp_quo;
    rsp_rem_d   = sp_div0_q[L-1] ? sp_a_q[L-1] : dp_rem;
    rsp_div0_d  = sp_v_q[L-1] & sp_div0_q[L-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      iss_v_q     <= 1'b0;
      sp_v_q      <= '0;
      rsp_valid_q <= '0;
      rsp_quo_q   <= '0;
      rsp_rem_q   <= '0;
      rsp_div0_q  <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      iss_v_q   <= gnt_any;
      sp_v_q[0] <= iss_v_q;
      for (int k = 1; k < L; k++) sp_v_q[k] <= sp_v_q[k-1];
      rsp_valid_q <= rsp_valid_d;
      rsp_quo_q   <= rsp_quo_d;
      rsp_rem_q   <= rsp_rem_d;
      rsp_div0_q  <= rsp_div0_d;
    end
  end

  // Payload only matters where the matching valid bit is set, so it carries no reset.
  always_ff @(posedge clk) begin
    if (gnt_any) begin
      iss_id_q   <= gnt_id;
      iss_div0_q <= (sel_b == '0);
      iss_a_q    <= sel_a;
      iss_b_q    <= sel_b;
    end
    sp_id_q[0]   <= iss_id_q;
    sp_div0_q[0] <= iss_div0_q;
    sp_a_q[0]    <= iss_a_q;
    for (int k = 1; k < L; k++) begin
      sp_id_q[k]   <= sp_id_q[k-1];
      sp_div0_q[k] <= sp_div0_q[k-1];
      sp_a_q[k]    <= sp_a_q[k-1];
    end
  end

  assign bus.req_ready     = grant;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_quotient  = rsp_quo_q;
  assign bus.rsp_remainder = rsp_rem_q;
  assign bus.rsp_div0      = rsp_div0_q;
  assign bus.busy          = iss_v_q | (|sp_v_q) | (|rsp_valid_q);
endmodule

// File: tb/tb_div_pipe_arb.sv
// Bench for div_pipe_arb: directed scenarios plus a random soak, all scored
// against a queue-based model of arbitration order and response timing.
module tb_div_pipe_arb;
  localparam int DW  = 32;
  localparam int OPS = 8;
  localparam int N   = 4;
  localparam int L   = DW / OPS;

  typedef struct {
    int          due;
    int          id;
    logic [31:0] q;
    logic [31:0] r;
    logic        d0;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  div_pipe_arb_if #(.DATA_W(DW), .N_REQ(N)) bus ();

  div_pipe_arb #(.DATA_W(DW), .OPERS_PER_STAGE(OPS), .N_REQ(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  rsp_t        sb[$];
  logic [31:0] opa [N];
  logic [31:0] opb [N];
  logic [N-1:0] pend;
  int          rr_ptr = 0;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;
  int          g;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive at the falling edge, check, then advance the model.
  task automatic do_cycle(input logic [N-1:0] v, input logic r, output int gid);
    rsp_t        e;
    logic [31:0] q, rm;
    int          id;
    @(negedge clk);
    rst = r;
    bus.req_valid = v;
    for (int i = 0; i < N; i++) begin
      bus.req_dividend[i*DW +: DW] = opa[i];
      bus.req_divisor[i*DW +: DW]  = opb[i];
    end
    #1;
    gid = -1;
    if (!r) begin
      for (int k = 0; k < N; k++) begin
        id = (rr_ptr + k) % N;
        if (gid < 0 && v[id]) gid = id;
      end
    end
    chk("req_ready", bus.req_ready, (gid < 0) ? 0 : (1 << gid));
    if (!r) begin
      chk("busy", bus.busy, sb.size() != 0);
      if (sb.size() != 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        chk("rsp_valid", bus.rsp_valid, 1 << e.id);
        chk("rsp_quotient", bus.rsp_quotient, e.q);
        chk("rsp_remainder", bus.rsp_remainder, e.r);
        chk("rsp_div0", bus.rsp_div0, e.d0);
      end else begin
        chk("rsp_valid_idle", bus.rsp_valid, 0);
      end
    end
    if (r) begin
      sb.delete();
      rr_ptr = 0;
    end else if (gid >= 0) begin
      if (opb[gid] == 0) begin
        q  = 32'hFFFF_FFFF;
        rm = opa[gid];
      end else begin
        q  = opa[gid] / opb[gid];
        rm = opa[gid] % opb[gid];
      end
      sb.push_back('{cyc + L + 2, gid, q, rm, opb[gid] == 0});
      rr_ptr = (gid + 1) % N;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    int dummy;
    for (int i = 0; i < n; i++) do_cycle('0, 1'b0, dummy);
  endtask

  initial begin
    bus.req_valid    = '0;
    bus.req_dividend = '0;
    bus.req_divisor  = '0;
    pend = '0;
    for (int i = 0; i < N; i++) begin
      opa[i] = 0;
      opb[i] = 0;
    end

    // Reset, then the output registers must read zero.
    for (int i = 0; i < 3; i++) do_cycle('0, 1'b1, g);
    do_cycle('0, 1'b0, g);
    chk("reset_quotient", bus.rsp_quotient, 0);
    chk("reset_remainder", bus.rsp_remainder, 0);
    chk("reset_div0", bus.rsp_div0, 0);

    // Single op from requester 2.
    opa[2] = 100; opb[2] = 7;
    do_cycle(4'b0100, 1'b0, g);
    idle(8);

    // Full contention from a fresh pointer.
    do_cycle('0, 1'b1, g);
    for (int i = 0; i < N; i++) begin
      opa[i] = 1000 + i;
      opb[i] = i + 3;
    end
    for (int i = 0; i < 12; i++) do_cycle(4'b1111, 1'b0, g);
    idle(8);

    // Divide by zero next to a normal op.
    opa[1] = 32'hDEAD_BEEF; opb[1] = 0;
    opa[2] = 50;            opb[2] = 5;
    do_cycle(4'b0010, 1'b0, g);
    do_cycle(4'b0100, 1'b0, g);
    idle(8);

    // Pointer fairness: after 3 is served, 0 beats 3.
    do_cycle(4'b1000, 1'b0, g);
    do_cycle(4'b1001, 1'b0, g);
    idle(8);

    // Reset with three ops in flight; nothing may come back.
    do_cycle(4'b0001, 1'b0, g);
    do_cycle(4'b0010, 1'b0, g);
    do_cycle(4'b0100, 1'b0, g);
    idle(2);
    do_cycle('0, 1'b1, g);
    idle(10);
    do_cycle(4'b1111, 1'b0, g);
    idle(8);

    // Random soak with operands held until handshake.
    pend = '0;
    for (int c = 0; c < 1000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          opa[i]  = $urandom & 32'h7FFF_FFFF;
          case ($urandom_range(0, 3))
            0:       opb[i] = 0;
            1:       opb[i] = $urandom_range(1, 255);
            default: opb[i] = $urandom & 32'h7FFF_FFFF;
          endcase
        end
      end
      do_cycle(pend, 1'b0, g);
      if (g >= 0) pend[g] = 1'b0;
    end
    idle(10);
    chk("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
